cache_arbiter: RTL and testbench
================================

# cache_arbiter

Shares the single physical-memory line port between the instruction cache and the data cache. Each cache presents its miss/writeback traffic on a `pmem_*`-style line interface. The arbiter picks one requester, latches its request, and drives the shared port until `pmem_resp`. It then returns read data and a one-cycle response to the winner. It sits between the two `cache` instances and the burst/memory model.

## Interface
Parameters:
- `ADDR_W`, 32, line address width
- `LINE_W`, 256, cacheline width in bits

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  asynchronous, active-low reset (asserted at 0)
- `ic_pmem_address`  in  ADDR_W  I-cache line address
- `ic_pmem_read`  in  1  I-cache line read request (I-cache never writes)
- `ic_pmem_rdata`  out  LINE_W  line returned to I-cache
- `ic_pmem_resp`  out  1  one-cycle completion pulse to I-cache
- `dc_pmem_address`  in  ADDR_W  D-cache line address
- `dc_pmem_read`  in  1  D-cache line read request
- `dc_pmem_write`  in  1  D-cache line writeback request
- `dc_pmem_wdata`  in  LINE_W  D-cache writeback line
- `dc_pmem_rdata`  out  LINE_W  line returned to D-cache
- `dc_pmem_resp`  out  1  one-cycle completion pulse to D-cache
- `pmem_address`  out  ADDR_W  shared port address
- `pmem_read`  out  1  shared port read
- `pmem_write`  out  1  shared port write
- `pmem_wdata`  out  LINE_W  shared port write data
- `pmem_rdata`  in  LINE_W  shared port read data
- `pmem_resp`  in  1  shared port completion

## Operation
- FSM states: IDLE, SERVE, DONE.
- `owner` register: IC or DC. `last` register: last requester served.
- IDLE:
  - A requester is pending when `ic_pmem_read`, or `dc_pmem_read | dc_pmem_write`, is high.
  - One pending requester wins.
  - Both pending: the requester not equal to `last` wins (round-robin).
  - The winner's address, wdata and read/write are latched into registers. `owner` is set. Next state is SERVE.
- SERVE:
  - `pmem_*` outputs are driven only from the latched registers. Requester inputs are ignored.
  - On `pmem_resp`=1: `pmem_rdata` is captured into the owner's rdata register, `last` is set to `owner`, and next state is DONE.
- DONE:
  - The owner's `*_pmem_resp`=1 for exactly this cycle. Rdata is valid this cycle and held until overwritten by the next read for that owner.
  - Requests are not sampled. Next state is IDLE.
- D-cache asserting read and write together is illegal. The arbiter treats it as a write, and a bench assertion flags it.
- Requester drops its request during SERVE: the transaction still completes on pmem and resp is still pulsed. There is no abort.
- The non-owner's resp stays 0 throughout. The non-owner's rdata is unchanged.

## Timing
- Reset (`rst`=0, async):
  - State IDLE, `last`=IC so DC wins the first tie.
  - All outputs 0: `pmem_read`, `pmem_write`, both resps, `pmem_address`, `pmem_wdata`, both rdata.
  - Reset mid-transaction forces outputs low immediately. The in-flight request is dropped.
- Request high at posedge N (state IDLE): `pmem_read`/`pmem_write` high from N+1.
- `pmem_resp` sampled at posedge M (state SERVE, M ≥ N+1): `pmem_read`/`pmem_write` low and `*_pmem_resp`=1 at M+1; state IDLE at M+2.
- Minimum latency with `pmem_resp` tied to 1 is 3 cycles request-to-IDLE; resp is seen in the cycle after N+1.
- A requester still asserting in the IDLE after its own DONE is treated as a new request. Requesters must deassert in the resp cycle.
- `pmem_read`/`pmem_write` never both 1. Both are 0 in IDLE and DONE.

## Structure
- `cache_arb_pkg`: state enum `arb_state_t` {IDLE, SERVE, DONE}, requester enum `arb_req_t` {IC, DC}, constants `LINE_W`=256 and `ADDR_W`=32.
- Single module. The winner pick is a few gates, so no sub-module is warranted. FSM, latch registers and rdata registers live in one file.

## Test plan
- Reset, then IC read 0x40000004 with `pmem_rdata`=0x600d…: `pmem_read` at N+1 with address 0x40000004; `ic_pmem_resp` pulses once; `ic_pmem_rdata`=0x600d…; `dc_pmem_resp` stays 0.
- DC write 0x50000000 with wdata 0xbeef… and `pmem_resp` delayed 5 cycles: `pmem_write`=1 and `pmem_wdata`=0xbeef… held for 5 cycles; single `dc_pmem_resp` pulse.
- IC and DC asserted in the same cycle right after reset: DC served first, then IC, with no idle cycle of starvation. On the next simultaneous pair, the winner alternates.
- DC deasserts its request mid-SERVE: the pmem transaction still completes and `dc_pmem_resp` still pulses.
- `rst` driven low during SERVE: `pmem_read` and resps fall to 0 asynchronously. After release, state is IDLE and a fresh IC request is served normally.
- Back-to-back IC reads with `pmem_resp` tied to 1: each completes in 3 cycles, and `ic_pmem_rdata` tracks each new line.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the I-cache / D-cache physical-memory arbiter.
package cache_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  // Requester identity, used for both the current owner and the last one served.
  typedef enum logic {
    IC = 1'b0,
    DC = 1'b1
  } arb_req_t;

  // Pick the requester to serve. On a tie, the one not served last wins, so
  // neither cache can starve the other.
  function automatic arb_req_t pick_winner(
    input logic     ic_pend,
    input logic     dc_pend,
    input arb_req_t last
  );
    arb_req_t win;
    if (ic_pend && dc_pend) begin
      win = (last == IC) ? DC : IC;
    end else if (dc_pend) begin
      win = DC;
    end else begin
      win = IC;
    end
    return win;
  endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Arbiter sharing one physical-memory line port between the I-cache and D-cache.
// A winner is picked in IDLE and its request is latched. The shared port is
// driven from the latched copy during SERVE. The winner then gets its line and
// a one-cycle resp pulse in DONE.
module cache_arbiter #(
  parameter int ADDR_W = cache_arb_pkg::ADDR_W,
  parameter int LINE_W = cache_arb_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] ic_pmem_address,
  input  logic              ic_pmem_read,
  output logic [LINE_W-1:0] ic_pmem_rdata,
  output logic              ic_pmem_resp,

  input  logic [ADDR_W-1:0] dc_pmem_address,
  input  logic              dc_pmem_read,
  input  logic              dc_pmem_write,
  input  logic [LINE_W-1:0] dc_pmem_wdata,
  output logic [LINE_W-1:0] dc_pmem_rdata,
  output logic              dc_pmem_resp,

  output logic [ADDR_W-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  import cache_arb_pkg::*;

  arb_state_t        state_q,    state_d;
  arb_req_t          owner_q,    owner_d;
  arb_req_t          last_q,     last_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [LINE_W-1:0] wdata_q,    wdata_d;
  logic              rd_q,       rd_d;
  logic              wr_q,       wr_d;
  logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
  logic              ic_resp_q,  ic_resp_d;
  logic              dc_resp_q,  dc_resp_d;

  logic              ic_pend_s;
  logic              dc_pend_s;
  arb_req_t          win_s;

  // Request detection and winner selection (only acted on in IDLE).
  always_comb begin
    ic_pend_s = ic_pmem_read;
    dc_pend_s = dc_pmem_read | dc_pmem_write;
    win_s     = pick_winner(ic_pend_s, dc_pend_s, last_q);
  end

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
    ic_resp_d  = 1'b0;
    dc_resp_d  = 1'b0;

    case (state_q)
      IDLE: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        if (ic_pend_s || dc_pend_s) begin
          owner_d = win_s;
          state_d = SERVE;
          if (win_s == DC) begin
            // Read+write together is illegal; it is resolved as a write.
            addr_d  = dc_pmem_address;
            wdata_d = dc_pmem_wdata;
            wr_d    = dc_pmem_write;
            rd_d    = ~dc_pmem_write;
          end else begin
            addr_d  = ic_pmem_address;
            wdata_d = {LINE_W{1'b0}};
            wr_d    = 1'b0;
            rd_d    = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SERVE: begin
        // Requester inputs are ignored here; the latched copy drives the port.
        if (pmem_resp) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          last_d  = owner_q;
          state_d = DONE;
          if (owner_q == DC) begin
            dc_resp_d = 1'b1;
            if (rd_q) begin
              dc_rdata_d = pmem_rdata;
            end else begin
              dc_rdata_d = dc_rdata_q;
            end
          end else begin
            ic_resp_d = 1'b1;
            if (rd_q) begin
              ic_rdata_d = pmem_rdata;
            end else begin
              ic_rdata_d = ic_rdata_q;
            end
          end
        end else begin
          state_d = SERVE;
        end
      end

      DONE: begin
        // Requests are not sampled in DONE; the owner must drop its request now.
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = IDLE;
      end

      default: begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= IC;
      last_q     <= IC;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {LINE_W{1'b0}};
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ic_rdata_q <= {LINE_W{1'b0}};
      dc_rdata_q <= {LINE_W{1'b0}};
      ic_resp_q  <= 1'b0;
      dc_resp_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      ic_resp_q  <= ic_resp_d;
      dc_resp_q  <= dc_resp_d;
    end
  end

  assign pmem_address  = addr_q;
  assign pmem_wdata    = wdata_q;
  assign pmem_read     = rd_q;
  assign pmem_write    = wr_q;
  assign ic_pmem_rdata = ic_rdata_q;
  assign dc_pmem_rdata = dc_rdata_q;
  assign ic_pmem_resp  = ic_resp_q;
  assign dc_pmem_resp  = dc_resp_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  localparam logic [LW-1:0] LINE_GOOD = {8{32'h600d_600d}};
  localparam logic [LW-1:0] LINE_BEEF = {16{16'hbeef}};
  localparam logic [LW-1:0] LINE_ZERO = {LW{1'b0}};

  logic          clk;
  logic          rst;
  logic [AW-1:0] ic_pmem_address;
  logic          ic_pmem_read;
  logic [LW-1:0] ic_pmem_rdata;
  logic          ic_pmem_resp;
  logic [AW-1:0] dc_pmem_address;
  logic          dc_pmem_read;
  logic          dc_pmem_write;
  logic [LW-1:0] dc_pmem_wdata;
  logic [LW-1:0] dc_pmem_rdata;
  logic          dc_pmem_resp;
  logic [AW-1:0] pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int n_cmp;
  int n_err;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk             (clk),
    .rst             (rst),
    .ic_pmem_address (ic_pmem_address),
    .ic_pmem_read    (ic_pmem_read),
    .ic_pmem_rdata   (ic_pmem_rdata),
    .ic_pmem_resp    (ic_pmem_resp),
    .dc_pmem_address (dc_pmem_address),
    .dc_pmem_read    (dc_pmem_read),
    .dc_pmem_write   (dc_pmem_write),
    .dc_pmem_wdata   (dc_pmem_wdata),
    .dc_pmem_rdata   (dc_pmem_rdata),
    .dc_pmem_resp    (dc_pmem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The D-cache must never assert read and write together.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(dc_pmem_read && dc_pmem_write))
        else $error("dc_pmem_read and dc_pmem_write asserted together");
    end
  end

  task automatic check_val(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Serve one transaction whose request is sampled at the next rising edge.
  // The owner drops its request after the first SERVE cycle. pmem_resp
  // arrives after `delay` active cycles. Returns at the first IDLE cycle
  // after DONE.
  task automatic serve_one(input string tag, input logic exp_dc, input logic [AW-1:0] exp_addr,
                           input logic exp_wr, input logic [LW-1:0] exp_wdata,
                           input logic [LW-1:0] rdata, input int delay);
    step();
    check_val({tag, "_rd"},   LW'(pmem_read),    LW'(!exp_wr));
    check_val({tag, "_wr"},   LW'(pmem_write),   LW'(exp_wr));
    check_val({tag, "_addr"}, LW'(pmem_address), LW'(exp_addr));
    if (exp_wr) check_val({tag, "_wdata"}, pmem_wdata, exp_wdata);
    if (exp_dc) begin
      dc_pmem_read  = 1'b0;
      dc_pmem_write = 1'b0;
    end else begin
      ic_pmem_read  = 1'b0;
    end
    for (int k = 1; k < delay; k++) begin
      step();
      check_val({tag, "_hold_act"},  LW'(exp_wr ? pmem_write : pmem_read), LW'(1'b1));
      check_val({tag, "_hold_addr"}, LW'(pmem_address), LW'(exp_addr));
      if (exp_wr) check_val({tag, "_hold_wdata"}, pmem_wdata, exp_wdata);
      check_val({tag, "_hold_noresp"}, LW'({ic_pmem_resp, dc_pmem_resp}), LW'(2'b00));
    end
    pmem_resp  = 1'b1;
    pmem_rdata = rdata;
    step();
    check_val({tag, "_ic_resp"}, LW'(ic_pmem_resp), LW'(!exp_dc));
    check_val({tag, "_dc_resp"}, LW'(dc_pmem_resp), LW'(exp_dc));
    check_val({tag, "_done_idle"}, LW'({pmem_read, pmem_write}), LW'(2'b00));
    if (!exp_wr) check_val({tag, "_rdata"}, exp_dc ? dc_pmem_rdata : ic_pmem_rdata, rdata);
    pmem_resp = 1'b0;
    step();
    check_val({tag, "_resp_cleared"}, LW'({ic_pmem_resp, dc_pmem_resp}), LW'(2'b00));
  endtask

  initial begin
    n_cmp           = 0;
    n_err           = 0;
    rst             = 1'b0;
    ic_pmem_address = {AW{1'b0}};
    ic_pmem_read    = 1'b0;
    dc_pmem_address = {AW{1'b0}};
    dc_pmem_read    = 1'b0;
    dc_pmem_write   = 1'b0;
    dc_pmem_wdata   = LINE_ZERO;
    pmem_rdata      = LINE_ZERO;
    pmem_resp       = 1'b0;

    // Reset state.
    step();
    step();
    check_val("rst_rd",       LW'(pmem_read),     LW'(1'b0));
    check_val("rst_wr",       LW'(pmem_write),    LW'(1'b0));
    check_val("rst_addr",     LW'(pmem_address),  LW'(32'h0000_0000));
    check_val("rst_wdata",    pmem_wdata,         LINE_ZERO);
    check_val("rst_resps",    LW'({ic_pmem_resp, dc_pmem_resp}), LW'(2'b00));
    check_val("rst_ic_rdata", ic_pmem_rdata,      LINE_ZERO);
    check_val("rst_dc_rdata", dc_pmem_rdata,      LINE_ZERO);

    // IC read, single-cycle memory response.
    rst             = 1'b1;
    ic_pmem_address = 32'h4000_0004;
    ic_pmem_read    = 1'b1;
    serve_one("ic_rd", 1'b0, 32'h4000_0004, 1'b0, LINE_ZERO, LINE_GOOD, 1);
    check_val("ic_rd_dc_rdata", dc_pmem_rdata, LINE_ZERO);

    // DC writeback with memory response after 5 cycles.
    dc_pmem_address = 32'h5000_0000;
    dc_pmem_wdata   = LINE_BEEF;
    dc_pmem_write   = 1'b1;
    serve_one("dc_wr", 1'b1, 32'h5000_0000, 1'b1, LINE_BEEF, LINE_ZERO, 5);
    check_val("dc_wr_ic_rdata", ic_pmem_rdata, LINE_GOOD);

    // Tie right after reset: DC first, then IC; then alternation.
    rst = 1'b0;
    step();
    rst             = 1'b1;
    ic_pmem_address = 32'h4000_0100;
    ic_pmem_read    = 1'b1;
    dc_pmem_address = 32'h5000_0100;
    dc_pmem_read    = 1'b1;
    serve_one("tie1_dc", 1'b1, 32'h5000_0100, 1'b0, LINE_ZERO, {8{32'h1111_0001}}, 1);
    serve_one("tie1_ic", 1'b0, 32'h4000_0100, 1'b0, LINE_ZERO, {8{32'h1111_0002}}, 1);
    check_val("tie1_dc_rdata_kept", dc_pmem_rdata, {8{32'h1111_0001}});

    ic_pmem_address = 32'h4000_0200;
    ic_pmem_read    = 1'b1;
    dc_pmem_address = 32'h5000_0200;
    dc_pmem_read    = 1'b1;
    serve_one("tie2_dc", 1'b1, 32'h5000_0200, 1'b0, LINE_ZERO, {8{32'h2222_0001}}, 1);
    dc_pmem_address = 32'h5000_0300;
    dc_pmem_read    = 1'b1;
    serve_one("tie3_ic", 1'b0, 32'h4000_0200, 1'b0, LINE_ZERO, {8{32'h2222_0002}}, 1);
    serve_one("tie3_dc", 1'b1, 32'h5000_0300, 1'b0, LINE_ZERO, {8{32'h2222_0003}}, 1);

    // DC drops its request mid-SERVE; transaction still completes.
    dc_pmem_address = 32'h5000_0400;
    dc_pmem_read    = 1'b1;
    serve_one("dc_drop", 1'b1, 32'h5000_0400, 1'b0, LINE_ZERO, {8{32'h3333_0004}}, 3);

    // Asynchronous reset during SERVE.
    ic_pmem_address = 32'h4000_0500;
    ic_pmem_read    = 1'b1;
    step();
    check_val("mid_rst_active", LW'(pmem_read), LW'(1'b1));
    #2 rst = 1'b0;
    #1;
    check_val("mid_rst_rd",     LW'(pmem_read),    LW'(1'b0));
    check_val("mid_rst_addr",   LW'(pmem_address), LW'(32'h0000_0000));
    check_val("mid_rst_resps",  LW'({ic_pmem_resp, dc_pmem_resp}), LW'(2'b00));
    check_val("mid_rst_rdata",  ic_pmem_rdata,     LINE_ZERO);
    ic_pmem_read = 1'b0;
    step();
    check_val("mid_rst_held",   LW'({pmem_read, pmem_write}), LW'(2'b00));
    rst             = 1'b1;
    ic_pmem_address = 32'h4000_0600;
    ic_pmem_read    = 1'b1;
    serve_one("post_rst", 1'b0, 32'h4000_0600, 1'b0, LINE_ZERO, {8{32'h4444_0006}}, 1);

    // Back-to-back IC reads with pmem_resp tied high: 3 cycles each.
    pmem_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ic_pmem_address = 32'h4000_1000 + 32'(i) * 32'h20;
      pmem_rdata      = {8{32'h7000_0000 + 32'(i)}};
      ic_pmem_read    = 1'b1;
      step();
      check_val("b2b_rd",    LW'(pmem_read),    LW'(1'b1));
      check_val("b2b_addr",  LW'(pmem_address), LW'(32'h4000_1000 + 32'(i) * 32'h20));
      step();
      check_val("b2b_resp",  LW'({ic_pmem_resp, dc_pmem_resp, pmem_read}), LW'(3'b100));
      check_val("b2b_rdata", ic_pmem_rdata, {8{32'h7000_0000 + 32'(i)}});
      step();
      check_val("b2b_idle",  LW'({ic_pmem_resp, pmem_read}), LW'(2'b00));
    end
    ic_pmem_read = 1'b0;
    pmem_resp    = 1'b0;
    step();
    check_val("final_idle", LW'({pmem_read, pmem_write}), LW'(2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
